// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single shared memory port. Two-state FSM (IDLE, ACCESS) with a per-access
// watchdog that aborts with an error flag after TIMEOUT cycles without ack.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between ports using a
// last-owner bit; when undefined the data port always wins ties.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic        if_err,
  output logic [31:0] if_rdata,
  // data port
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        dm_we,
  output logic        dm_gnt,
  output logic        dm_done,
  output logic        dm_err,
  output logic [31:0] dm_rdata,
  // shared memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;       // 1 = data port owns the access
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] wdog_q, wdog_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_gnt_q, if_gnt_d;
  logic        dm_gnt_q, dm_gnt_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        if_err_q, if_err_d;
  logic        dm_err_q, dm_err_d;
  logic        pick_dm;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;         // last owner, 0 = fetch

  // Tie goes to whichever port was not served last.
  always_comb begin
    pick_dm = dm_req && (!if_req || !last_q);
  end
`else
  // Data port always wins a tie.
  always_comb begin
    pick_dm = dm_req;
  end
`endif

  // Next-state and pulse outputs for the IDLE/ACCESS FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wdog_d     = wdog_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_err_d   = 1'b0;
    dm_err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ACCESS;
          owner_d  = pick_dm;
          addr_d   = pick_dm ? dm_addr : if_addr;
          we_d     = pick_dm && dm_we;
          wdata_d  = pick_dm ? dm_wdata : 32'd0;
          wdog_d   = 16'd0;
          if_gnt_d = !pick_dm;
          dm_gnt_d = pick_dm;
`ifdef ARB_ROUND_ROBIN_EN
          last_d   = pick_dm;
`endif
        end
      end
      ACCESS: begin
        // Ack beats the watchdog when both happen in the same cycle.
        if (mem_ack) begin
          state_d = IDLE;
          if (owner_q) begin
            dm_done_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LIMIT)) begin
          state_d = IDLE;
          if (owner_q) begin
            dm_done_d = 1'b1;
            dm_err_d  = 1'b1;
          end else begin
            if_done_d = 1'b1;
            if_err_d  = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous reset clears every flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      wdog_q     <= 16'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      dm_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wdog_q     <= wdog_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_err_q   <= if_err_d;
      dm_err_q   <= dm_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_err    = if_err_q;
  assign dm_err    = dm_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the stimulus computes the expected grant
// order from the arbitration rules and queues one record per access; a
// memory responder serves accesses from the same records, and a monitor
// pops and checks grants, bus contents, completion latency, err and rdata.
module tb_mem_arbiter;
  localparam int TO = 15;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 0, reset = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err;
  logic mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_err(if_err), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          to;   // memory never acks -> watchdog abort expected
    int          w;    // wait cycles before ack
  } txn_t;

  txn_t exp_q[$];
  txn_t plan_q[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  bit act = 0;
  bit spur_en = 0, poke_ack = 0;
  bit m_last = 0;
  logic [31:0] m_if_rd = 0, m_dm_rd = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic txn_t mk(bit dm);
    txn_t t;
    t.dm    = dm;
    t.addr  = $urandom;
    t.we    = dm ? 1'($urandom_range(0, 1)) : 1'b0;
    t.wdata = $urandom;
    t.rd    = $urandom;
    case ($urandom_range(0, 6))
      0, 1:    t.w = 0;
      2:       t.w = 1;
      3:       t.w = 2;
      4:       t.w = 3;
      5:       t.w = TO;
      default: t.w = TO + 1;
    endcase
    t.to = (t.w > TO);
    return t;
  endfunction

  task automatic push(txn_t t);
    exp_q.push_back(t);
    plan_q.push_back(t);
    m_last = t.dm;
  endtask

  // Issue one or two requests; winner order comes from the arbitration rule.
  task automatic drive(bit wi, txn_t ti, bit wd, txn_t td);
    int n;
    bit first_dm;
    if (wi && wd) begin
      first_dm = RR ? !m_last : 1'b1;
      if (first_dm) begin push(td); push(ti); end
      else begin push(ti); push(td); end
    end else if (wd) push(td);
    else if (wi) push(ti);
    if_addr = ti.addr; if_req = wi;
    dm_addr = td.addr; dm_we = td.we; dm_wdata = td.wdata; dm_req = wd;
    n = 0;
    while ((if_req || dm_req || exp_q.size() != 0 || act) && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("gnt_latency", 32'(if_gnt | dm_gnt), 1);
      if (if_gnt) if_req = 0;
      if (dm_gnt) dm_req = 0;
    end
    if (n >= 300) flag("drain_timeout");
    if_req = 0; dm_req = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, 32'({if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err, mem_en, mem_we, busy}), 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_ifrd"}, if_rdata, 0);
    chk({tag, "_dmrd"}, dm_rdata, 0);
  endtask

  // Memory model: acks after the planned wait, optional stray acks in idle.
  initial begin
    txn_t cur;
    int cnt = 0;
    bit serving = 0;
    cur = mk(0);
    forever begin
      @(posedge clk); #2;
      mem_ack = 0;
      if (!mem_en) serving = 0;
      if (mem_en && !serving) begin
        serving = 1;
        cnt = 0;
        if (plan_q.size() == 0) begin
          flag("unplanned_access");
          cur.to = 1;
        end else cur = plan_q.pop_front();
      end
      if (serving) begin
        if (!cur.to && cnt == cur.w) begin
          mem_ack = 1;
          mem_rdata = cur.rd;
        end
        cnt++;
      end else if (poke_ack) begin
        poke_ack = 0;
        mem_ack = 1;
        mem_rdata = $urandom;
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        mem_ack = 1;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on each grant, checks on each done.
  initial begin
    txn_t cur;
    int gcyc = 0, lat;
    bit bus_bad = 0;
    cur = mk(0);
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        act = 0;
        exp_q.delete();
        plan_q.delete();
        m_if_rd = 0;
        m_dm_rd = 0;
      end else begin
        if (if_gnt || dm_gnt) begin
          chk("single_gnt", 32'(if_gnt & dm_gnt), 0);
          if (exp_q.size() == 0) flag("unexpected_gnt");
          else begin
            cur = exp_q.pop_front();
            chk("gnt_port", 32'(dm_gnt), 32'(cur.dm));
            act = 1;
            gcyc = cyc;
            bus_bad = 0;
          end
        end
        if (mem_en && act)
          if (mem_addr !== cur.addr || mem_we !== cur.we || (cur.we && mem_wdata !== cur.wdata))
            bus_bad = 1;
        if (if_done || dm_done) begin
          if (!act) flag("spurious_done");
          else begin
            lat = cur.to ? TO + 1 : cur.w + 1;
            chk("done_port", 32'(dm_done), 32'(cur.dm));
            chk("done_err", 32'(cur.dm ? dm_err : if_err), 32'(cur.to));
            chk("done_latency", 32'(cyc - gcyc), 32'(lat));
            chk("bus_stable", 32'(bus_bad), 0);
            chk("busy_at_done", 32'(busy), 0);
            if (!cur.to && !cur.we) begin
              if (cur.dm) m_dm_rd = cur.rd;
              else m_if_rd = cur.rd;
            end
            chk("if_rdata", if_rdata, m_if_rd);
            chk("dm_rdata", dm_rdata, m_dm_rd);
            act = 0;
          end
        end
        if ((if_err && !if_done) || (dm_err && !dm_done)) flag("err_without_done");
      end
    end
  end

  initial begin
    txn_t ti, td;
    int gc[4];
    int ng, n;
    logic [3:0] order, exp_order;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;
    @(posedge clk); #1;

    // Both ports held for four grants, each re-request is again a tie.
    ti = mk(0); ti.w = 0; ti.to = 0;
    td = mk(1); td.w = 0; td.to = 0;
    for (int k = 0; k < 4; k++) begin
      if (RR ? !m_last : 1'b1) push(td); else push(ti);
    end
    exp_order = RR ? 4'b0101 : 4'b1111;   // bit k = grant k went to data
    if_addr = ti.addr; if_req = 1;
    dm_addr = td.addr; dm_we = td.we; dm_wdata = td.wdata; dm_req = 1;
    ng = 0; n = 0; order = 0;
    while (ng < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (if_gnt || dm_gnt) begin
        gc[ng] = n;
        order[ng] = dm_gnt;
        ng++;
      end
    end
    if_req = 0; dm_req = 0;
    if (ng < 4) flag("tie_timeout");
    chk("tie_order", 32'(order), 32'(exp_order));
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 32'(gc[k] - gc[k-1]), 2);
    n = 0;
    while ((exp_q.size() != 0 || act) && n < 100) begin @(posedge clk); #1; n++; end

    // Single fetch.
    ti = mk(0); ti.addr = 32'h10; ti.rd = 32'h20100001; ti.w = 0; ti.to = 0;
    drive(1, ti, 0, td);
    chk("fetch_rdata", if_rdata, 32'h20100001);
    chk("fetch_err", 32'(if_err), 0);

    // Store with three wait states.
    td = mk(1); td.addr = 32'h8; td.we = 1; td.wdata = 32'h1F4; td.w = 3; td.to = 0;
    drive(0, ti, 1, td);

    // Watchdog abort, then ack on the final allowed cycle.
    ti = mk(0); ti.w = TO + 1; ti.to = 1;
    drive(1, ti, 0, td);
    chk("timeout_busy", 32'(busy), 0);
    ti = mk(0); ti.w = TO; ti.to = 0;
    drive(1, ti, 0, td);

    // Randomized traffic with stray acks while idle.
    spur_en = 1;
    for (int k = 0; k < 60; k++) begin
      int p;
      p = $urandom_range(0, 2);
      drive(p != 1, mk(0), p != 0, mk(1));
    end
    spur_en = 0;

    // Reset in the middle of an access, then a stale ack.
    ti = mk(0); ti.w = TO + 1; ti.to = 1;
    push(ti);
    if_addr = ti.addr; if_req = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!if_gnt && n < 50);
    if_req = 0;
    if (n >= 50) flag("rst_gnt_timeout");
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    poke_ack = 1;
    m_last = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_zero("post_reset");
    end
    ti = mk(0); ti.w = 1; ti.to = 0;
    drive(1, ti, 0, td);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
